// File: rtl/mult_dispatcher.sv
// Front-end controller for the signed 32x32 sequential multiplier: queues operand
// pairs, launches one op at a time with a start pulse, and hands the product downstream.
module mult_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        mul_start,
    output logic [31:0] mul_multiplicand,
    output logic [31:0] mul_multiplier,
    input  logic [63:0] mul_product,
    input  logic        mul_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_product,
    output logic        busy,
    output logic        timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_WAIT,
        S_OUT
    } state_t;

    logic [31:0]   mem_a_q [DEPTH];
    logic [31:0]   mem_b_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [31:0]   head_a;
    logic [31:0]   head_b;

    state_t        state_q;
    logic          mul_start_q;
    logic [31:0]   mul_a_q;
    logic [31:0]   mul_b_q;
    logic          out_valid_q;
    logic [63:0]   out_product_q;
    logic          timeout_err_q;
    logic [TW-1:0] timer_q;
    logic          timer_expired;

    // A pop in the same cycle never frees a slot for a push while full.
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign head_a     = mem_a_q[rd_ptr_q];
    assign head_b     = mem_b_q[rd_ptr_q];

    assign timer_expired = (timer_q == TW'(TIMEOUT - 1));
    // The head entry stays queued until its op resolves (done or abandoned).
    assign pop = (state_q == S_WAIT) && (mul_done || timer_expired);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mul_start_q   <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            mul_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        mul_a_q     <= head_a;
                        mul_b_q     <= head_b;
                        mul_start_q <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_ARM;
                end
                // Guard cycle: a done still visible here belongs to an earlier op.
                S_ARM: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        out_product_q <= mul_product;
                        out_valid_q   <= 1'b1;
                        state_q       <= S_OUT;
                    end else if (timer_expired) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!fifo_empty) begin
                            mul_a_q     <= head_a;
                            mul_b_q     <= head_b;
                            mul_start_q <= 1'b1;
                            state_q     <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mul_start        = mul_start_q;
    assign mul_multiplicand = mul_a_q;
    assign mul_multiplier   = mul_b_q;
    assign out_valid        = out_valid_q;
    assign out_product      = out_product_q;
    assign timeout_err      = timeout_err_q;
    assign busy             = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mult_dispatcher.sv
// Scoreboard bench for mult_dispatcher with a behavioural multiplier stub of latency L.
module tb_mult_dispatcher;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int L       = 34;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        mul_start;
    logic [31:0] mul_multiplicand;
    logic [31:0] mul_multiplier;
    logic [63:0] mul_product;
    logic        mul_done;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;
    logic        busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    mult_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: reads its operands when it finishes.
    logic        stub_running;
    int          stub_cnt;
    logic        stub_done;
    logic [63:0] stub_prod;
    logic        force_done;
    logic        no_done;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_running <= 1'b0;
            stub_cnt     <= 0;
            stub_done    <= 1'b0;
            stub_prod    <= '0;
        end else if (mul_start) begin
            stub_running <= 1'b1;
            stub_cnt     <= L;
            stub_done    <= 1'b0;
        end else if (stub_running) begin
            if (stub_cnt == 1) begin
                stub_running <= 1'b0;
                stub_done    <= !no_done;
                stub_prod    <= smul(mul_multiplicand, mul_multiplier);
            end
            stub_cnt <= stub_cnt - 1;
        end
    end

    assign mul_done    = stub_done | force_done;
    assign mul_product = stub_prod;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: samples 1 time unit after each falling edge.
    int          cyc = 0;
    int          start_cyc = 0;
    int          start_pulses = 0;
    logic        ov_prev = 1'b0;
    logic        acc_prev = 1'b0;
    logic [63:0] prod_prev = '0;
    int          n_out = 0;

    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (rst) begin
            ov_prev  = 1'b0;
            acc_prev = 1'b0;
        end else begin
            if (mul_start) begin
                start_cyc = cyc;
                start_pulses++;
            end
            if (out_valid && !ov_prev)
                check("latency", 64'(cyc - start_cyc), 64'(L + 2));
            if (out_valid && ov_prev && !acc_prev)
                check("out_hold", out_product, prod_prev);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h, required no output", out_product);
                end else begin
                    $display("out #%0d product=%h expected=%h", n_out, out_product, exp_q[0]);
                    check("product", out_product, exp_q.pop_front());
                end
            end
            acc_prev  = out_valid && out_ready;
            ov_prev   = out_valid;
            prod_prev = out_product;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] e, input bit expect_out);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int n = 0; n < 300; n++) begin
            if (in_ready) begin
                acc = 1'b1;
                if (expect_out) exp_q.push_back(e);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        $display("push a=%h b=%h accepted=%0d", a, b, acc);
        check("push_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (mul_start) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("start_seen", 64'(ok), 64'd1);
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (exp_q.size() == 0 && !busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("drained", 64'(ok), 64'd1);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_multiplicand", 64'(mul_multiplicand), 64'd0);
        check("rst_multiplier", 64'(mul_multiplier), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_product", out_product, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int sp0;
        int k;
        int mism;
        int ovc;
        int seen;
        bit ok;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b1;
        force_done = 1'b0;
        no_done    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        // Single op (-7 * 6) and push-to-start timing
        sp0 = start_pulses;
        push(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b1);
        check("start_not_yet", 64'(mul_start), 64'd0);
        check("busy_after_push", 64'(busy), 64'd1);
        @(negedge clk);
        check("start_pulse", 64'(mul_start), 64'd1);
        @(negedge clk);
        check("start_one_cycle", 64'(mul_start), 64'd0);
        drain(200);
        check("start_count", 64'(start_pulses - sp0), 64'd1);

        // Back-pressure: six ops through a four-entry queue
        out_ready = 1'b0;
        push(32'd1, 32'd1, 64'h0000_0000_0000_0001, 1'b1);
        push(32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
        push(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1);
        push(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        push(32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006, 1'b1);
        for (int n = 0; n < 10; n++) @(negedge clk);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_product", out_product, 64'h0000_0000_0000_0001);
        check("bp_full_again", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        push(32'd100, 32'd7, 64'h0000_0000_0000_02BC, 1'b1);
        drain(600);

        // Stale done held high until the guard cycle has passed
        force_done = 1'b1;
        push(32'd2, 32'd3, 64'h0000_0000_0000_0006, 1'b1);
        wait_start();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        force_done = 1'b0;
        check("stale_no_early_out", 64'(out_valid), 64'd0);
        drain(200);

        // Operand hold through START..accept, with a stalled consumer
        out_ready = 1'b0;
        push(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
        wait_start();
        mism = 0;
        ovc  = 0;
        ok   = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (mul_multiplicand !== 32'h8000_0000 || mul_multiplier !== 32'hFFFF_FFFF) mism++;
            if (out_valid) begin
                ovc++;
                if (ovc == 5) out_ready = 1'b1;
            end else if (ovc > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("hold_completed", 64'(ok), 64'd1);
        check("operand_hold", 64'(mism), 64'd0);
        out_ready = 1'b1;
        drain(50);

        // Timeout: first op never completes, the queued one does
        no_done = 1'b1;
        push(32'd5, 32'd5, 64'd0, 1'b0);
        wait_start();
        check("to_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = 32'hFFFF_FFFD;
        in_b     = 32'd4;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF4);
        $display("push a=%h b=%h accepted=1", in_a, in_b);
        k    = 0;
        seen = 0;
        ok   = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            k++;
            if (out_valid) seen++;
            if (timeout_err) begin
                ok = 1'b1;
                break;
            end
        end
        no_done = 1'b0;
        check("timeout_flag", 64'(ok), 64'd1);
        check("timeout_cycles", 64'(k), 64'(TIMEOUT + 2));
        check("timeout_no_out", 64'(seen), 64'd0);
        drain(200);
        check("timeout_sticky", 64'(timeout_err), 64'd1);

        // Reset in WAIT cycle 10 with two ops queued
        push(32'd9, 32'd9, 64'd0, 1'b0);
        wait_start();
        in_valid = 1'b1;
        in_a     = 32'd1;
        in_b     = 32'd2;
        @(negedge clk);
        in_a     = 32'd3;
        in_b     = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        k = 2;
        while (k < 12) begin
            @(negedge clk);
            k++;
        end
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (out_valid || mul_start) seen++;
        end
        check("post_rst_quiet", 64'(seen), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        // Recovery after reset
        push(32'd6, 32'd7, 64'h0000_0000_0000_002A, 1'b1);
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
